// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for 24-bit stereo tone-generator samples.
// Derives bclk/lrclk from sys_clk with an integer divider and keeps one
// stereo frame in a holding buffer. At each frame boundary that frame moves
// into the shift registers. If no fresh frame is waiting, the previous frame
// is sent again and a one-cycle underrun pulse is raised.
module i2s_tx #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    // Divider width never drops to zero, even when BCLK_DIV is 1
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] SAMP_LEN = CNT_W'(SAMPLE_W);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_bclk;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_lrclk;
    logic                r_sdata;
    logic                r_underrun;
    logic                r_ready;      // 1 = holding buffer empty
    logic [SAMPLE_W-1:0] r_buf_l;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic [SAMPLE_W-1:0] r_shift_l;
    logic [SAMPLE_W-1:0] r_shift_r;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    logic                w_tick;
    logic                w_fall;
    logic [DIV_W-1:0]    w_div_nxt;
    logic                w_bclk_nxt;
    logic [CNT_W-1:0]    w_bit_step;
    logic                w_wrap;
    logic                w_in_right;
    logic [CNT_W-1:0]    w_k;
    logic [SAMPLE_W-1:0] w_sel;
    logic [SAMPLE_W-1:0] w_shifted;
    logic                w_data_bit;
    logic                w_accept;
    logic                w_load;
    logic                w_ready_nxt;
    logic                w_underrun_nxt;

    // Bit-clock divider: wrap at terminal count and toggle bclk
    always_comb begin
        w_tick     = (r_div_cnt == DIV_LAST);
        w_fall     = w_tick && r_bclk;
        w_div_nxt  = r_div_cnt;
        w_bclk_nxt = r_bclk;
        if (w_tick) begin
            w_div_nxt  = '0;
            w_bclk_nxt = ~r_bclk;
        end else begin
            w_div_nxt  = r_div_cnt + DIV_W'(1);
            w_bclk_nxt = r_bclk;
        end
    end

    // Bit position and serial data for the slot entered at the next falling bclk
    always_comb begin
        w_bit_step = '0;
        if (r_bit_cnt == CNT_LAST) begin
            w_bit_step = '0;
        end else begin
            w_bit_step = r_bit_cnt + CNT_W'(1);
        end
        w_wrap     = w_fall && (r_bit_cnt == CNT_LAST);
        w_in_right = (w_bit_step >= SLOT_LEN);
        w_k        = '0;
        w_sel      = '0;
        if (w_in_right) begin
            w_k   = w_bit_step - SLOT_LEN;
            w_sel = r_shift_r;
        end else begin
            w_k   = w_bit_step;
            w_sel = r_shift_l;
        end
        // Bit k (1..SAMPLE_W) is sample bit SAMPLE_W-k, brought to the MSB.
        // k=0 is the one-bclk I2S delay slot. It is always 0, so a frame
        // loaded in the same cycle is never needed here.
        w_shifted  = w_sel << (w_k - CNT_W'(1));
        w_data_bit = 1'b0;
        if ((w_k != '0) && (w_k <= SAMP_LEN)) begin
            w_data_bit = w_shifted[SAMPLE_W-1];
        end else begin
            w_data_bit = 1'b0;
        end
    end

    // Holding-buffer handshake, frame load and underrun decision
    always_comb begin
        w_accept       = sample_valid && r_ready;
        // A frame accepted in this very cycle is not visible to the load
        w_load         = w_wrap && !r_ready;
        w_underrun_nxt = w_wrap && r_ready;
        w_ready_nxt    = r_ready;
        if (w_load) begin
            w_ready_nxt = 1'b1;
        end else if (w_accept) begin
            w_ready_nxt = 1'b0;
        end else begin
            w_ready_nxt = r_ready;
        end
    end

    // Divider, bclk, ready flag and underrun pulse registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_ready    <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_nxt;
            r_bclk     <= w_bclk_nxt;
            r_ready    <= w_ready_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    // Bit counter, word select and serial data advance only on falling bclk
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bit_cnt <= CNT_LAST;
            r_lrclk   <= 1'b1;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_step;
            r_lrclk   <= w_in_right;
            r_sdata   <= w_data_bit;
        end else begin
            r_bit_cnt <= r_bit_cnt;
            r_lrclk   <= r_lrclk;
            r_sdata   <= r_sdata;
        end
    end

    // Holding buffer captures a frame on valid && ready
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else if (w_accept) begin
            r_buf_l <= left_in;
            r_buf_r <= right_in;
        end else begin
            r_buf_l <= r_buf_l;
            r_buf_r <= r_buf_r;
        end
    end

    // Shift registers take the held frame at a boundary, otherwise repeat
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (w_load) begin
            r_shift_l <= r_buf_l;
            r_shift_r <= r_buf_r;
        end else begin
            r_shift_l <= r_shift_l;
            r_shift_r <= r_shift_r;
        end
    end

    assign sample_ready = r_ready;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed, table-driven bench for i2s_tx. One instance uses the
// default parameters. A second instance uses BCLK_DIV=1 and SLOT_W=25.
module tb_i2s_tx;

    logic        sys_clk;
    logic        rst;
    logic [23:0] left_in;
    logic [23:0] right_in;
    logic        valid;
    logic        ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    logic        rst2;
    logic [23:0] left2;
    logic [23:0] right2;
    logic        valid2;
    logic        ready2;
    logic        bclk2;
    logic        lrclk2;
    logic        sdata2;
    logic        underrun2;

    i2s_tx dut (
        .sys_clk      (sys_clk),
        .sys_rst      (rst),
        .left_in      (left_in),
        .right_in     (right_in),
        .sample_valid (valid),
        .sample_ready (ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    i2s_tx #(.SAMPLE_W(24), .SLOT_W(25), .BCLK_DIV(1)) dut2 (
        .sys_clk      (sys_clk),
        .sys_rst      (rst2),
        .left_in      (left2),
        .right_in     (right2),
        .sample_valid (valid2),
        .sample_ready (ready2),
        .bclk         (bclk2),
        .lrclk        (lrclk2),
        .sdata        (sdata2),
        .underrun     (underrun2)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t tab [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the default instance. It counts cycles since reset release,
    // records frame boundaries and underrun pulses, and captures sdata/lrclk
    // at each falling bclk.
    int          cyc;
    int          fall_k;
    logic        prev_b;
    logic [63:0] cap_d;
    logic [63:0] cap_lr;
    logic [63:0] q_d [$];
    logic [63:0] q_lr [$];
    int          bnd_q [$];
    int          ur_q [$];

    initial begin
        cyc    = 0;
        fall_k = 0;
        prev_b = 1'b0;
        cap_d  = '0;
        cap_lr = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (rst) begin
                cyc    = 0;
                fall_k = 0;
                prev_b = 1'b0;
            end else begin
                cyc++;
                if (underrun) ur_q.push_back(cyc);
                if (prev_b && !bclk) begin
                    if (fall_k == 0) bnd_q.push_back(cyc);
                    cap_d[63-fall_k]  = sdata;
                    cap_lr[63-fall_k] = lrclk;
                    if (fall_k == 63) begin
                        q_d.push_back(cap_d);
                        q_lr.push_back(cap_lr);
                        fall_k = 0;
                    end else begin
                        fall_k++;
                    end
                end
                prev_b = bclk;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            step();
            guard++;
        end
        check("wait_cyc", 64'(cyc), 64'(target));
    endtask

    initial begin : main
        int          rise;
        int          exp_bnd [8];
        int          exp_ur [5];
        int          fidx [5];
        int          c2;
        int          k2;
        int          nf2;
        int          toggles;
        logic        prev2;
        logic [49:0] cap2;
        int          bnd2 [$];
        int          ur2 [$];

        tab[0].l = 24'h800001; tab[0].r = 24'h7FFFFE;
        tab[0].exp_l = 32'h40000080; tab[0].exp_r = 32'h3FFFFF00;
        tab[1].l = 24'hFFFFFF; tab[1].r = 24'h000000;
        tab[1].exp_l = 32'h7FFFFF80; tab[1].exp_r = 32'h00000000;
        tab[2].l = 24'hA5A5A5; tab[2].r = 24'h654321;
        tab[2].exp_l = 32'h52D2D280; tab[2].exp_r = 32'h32A19080;
        fidx    = '{0, 1, 1, 2, 2};
        exp_bnd = '{8, 520, 1032, 1544, 2056, 2568, 8, 520};
        exp_ur  = '{1032, 2056, 2568, 8, 520};

        rst = 1'b1; valid = 1'b0; left_in = '0; right_in = '0;
        rst2 = 1'b1; valid2 = 1'b0; left2 = '0; right2 = '0;
        repeat (3) step();

        // Reset state
        check("rst_bclk", 64'(bclk), 64'd0);
        check("rst_lrclk", 64'(lrclk), 64'd1);
        check("rst_sdata", 64'(sdata), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);

        // Frame A is presented with valid already high when reset is released
        left_in = tab[0].l; right_in = tab[0].r; valid = 1'b1;
        rst = 1'b0;
        step();
        check("accept_a_c1", 64'(ready), 64'd0);

        // Backpressure: B waits until A loads at the first boundary
        left_in = tab[1].l; right_in = tab[1].r;
        rise = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ready) begin
                rise = cyc;
                break;
            end
        end
        check("ready_rise_cyc", 64'(rise), 64'd8);
        step();
        check("accept_b_c9", 64'(ready), 64'd0);
        valid = 1'b0;

        // Valid arrives in the same cycle as the frame load while the buffer is empty
        wait_cyc(1031);
        left_in = tab[2].l; right_in = tab[2].r; valid = 1'b1;
        step();
        check("same_cycle_underrun", 64'(underrun), 64'd1);
        check("same_cycle_accept", 64'(ready), 64'd0);
        valid = 1'b0;
        wait_cyc(1544);
        check("ready_after_load", 64'(ready), 64'd1);

        // Fill the buffer again so that reset has a frame to discard
        wait_cyc(2600);
        left_in = tab[0].l; right_in = tab[0].r; valid = 1'b1;
        step();
        check("accept_before_rst", 64'(ready), 64'd0);
        valid = 1'b0;

        // Reset mid-frame at bit_cnt=40 while bclk is high
        wait_cyc(2893);
        check("pre_rst_bclk", 64'(bclk), 64'd1);
        check("pre_rst_sdata", 64'(sdata), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_bclk", 64'(bclk), 64'd0);
        check("mid_rst_lrclk", 64'(lrclk), 64'd1);
        check("mid_rst_sdata", 64'(sdata), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd1);
        repeat (2) step();
        rst = 1'b0;
        wait_cyc(520);

        // Captured frames against the table of expected frames
        check("frame_count", 64'(q_d.size()), 64'd6);
        for (int i = 0; i < 5; i++) begin
            if (i < q_d.size()) begin
                check($sformatf("frame%0d_sdata", i), q_d[i], {tab[fidx[i]].exp_l, tab[fidx[i]].exp_r});
                check($sformatf("frame%0d_lrclk", i), q_lr[i], 64'h00000000_FFFFFFFF);
            end
        end
        if (q_d.size() > 5) begin
            check("post_rst_frame_sdata", q_d[5], 64'h0);
            check("post_rst_frame_lrclk", q_lr[5], 64'h00000000_FFFFFFFF);
        end
        check("boundary_count", 64'(bnd_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < bnd_q.size()) check($sformatf("boundary%0d_cyc", i), 64'(bnd_q[i]), 64'(exp_bnd[i]));
        end
        check("underrun_count", 64'(ur_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ur_q.size()) check($sformatf("underrun%0d_cyc", i), 64'(ur_q[i]), 64'(exp_ur[i]));
        end

        // BCLK_DIV=1, SLOT_W=25 instance: no padding bits, 100-cycle frame
        left2 = 24'hC00001; right2 = 24'h000003; valid2 = 1'b1;
        rst2 = 1'b0;
        c2 = 0; k2 = 0; nf2 = 0; toggles = 0; prev2 = 1'b0; cap2 = '0;
        for (int i = 0; i < 110; i++) begin
            step();
            c2++;
            if (bclk2 != prev2) toggles++;
            if (underrun2) ur2.push_back(c2);
            if (prev2 && !bclk2) begin
                if (k2 == 0) bnd2.push_back(c2);
                if (nf2 == 0) cap2[49-k2] = sdata2;
                if (k2 == 49) begin
                    k2 = 0;
                    nf2++;
                end else begin
                    k2++;
                end
            end
            prev2 = bclk2;
            if (c2 == 1) begin
                check("div1_accept", 64'(ready2), 64'd0);
                valid2 = 1'b0;
            end
        end
        check("div1_toggles", 64'(toggles), 64'd110);
        check("div1_frame", 64'(cap2), 64'({1'b0, 24'hC00001, 1'b0, 24'h000003}));
        check("div1_boundaries", 64'(bnd2.size()), 64'd2);
        if (bnd2.size() >= 2) begin
            check("div1_first_fall", 64'(bnd2[0]), 64'd2);
            check("div1_frame_len", 64'(bnd2[1] - bnd2[0]), 64'd100);
        end
        check("div1_underruns", 64'(ur2.size()), 64'd1);
        if (ur2.size() >= 1) check("div1_underrun_cyc", 64'(ur2[0]), 64'd102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
